// File: rtl/mem_client_port_pkg.sv
// Shared widths, opcode encoding and request record for the memory client port.
package mem_client_port_pkg;

    localparam int ADDR_W      = 17;
    localparam int DATA_W      = 32;
    localparam int OP_W        = 4;
    localparam int NUM_CLIENTS = 3;

    localparam logic [OP_W-1:0] OP_READ = 4'b0000;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wrdata;
        logic [OP_W-1:0]   op;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    function automatic logic is_read(input logic [OP_W-1:0] op);
        return op == OP_READ;
    endfunction

endpackage

// File: rtl/mem_client_port_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry an extra wrap bit for full/empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign do_pop  = pop & ~empty;
    // A full FIFO may still take a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[PTR_W-1:0]] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr_reg[PTR_W-1:0]];

endmodule

// File: rtl/mem_client_port.sv
// Engine-side memory client: queues requests toward the arbiter and collects
// this client's broadcast read returns, limiting reads to the return buffer space.
module mem_client_port
    import mem_client_port_pkg::*;
#(
    parameter int REQ_DEPTH  = 4,
    parameter int RD_DEPTH   = 4,
    parameter int CLIENT_IDX = 0
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wrdata,
    input  logic [OP_W-1:0]        req_op,
    output logic                   arb_rts,
    input  logic                   arb_rtr,
    output logic [ADDR_W-1:0]      arb_addr,
    output logic [DATA_W-1:0]      arb_wrdata,
    output logic [OP_W-1:0]        arb_op,
    input  logic [DATA_W-1:0]      bcast_data,
    input  logic [NUM_CLIENTS-1:0] bcast_xfc,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [DATA_W-1:0]      rd_data,
    output logic [2:0]             rd_outstanding,
    output logic                   busy,
    output logic                   err
);
    localparam int CRED_W = $clog2(RD_DEPTH + 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(RD_DEPTH);

    req_t              req_in;
    req_t              req_head;
    logic              req_full, req_empty;
    logic              rd_full, rd_empty;
    logic [CRED_W-1:0] credits_reg;
    logic [2:0]        rd_outstanding_reg;
    logic              err_reg;

    logic accept, rd_accept, xfc, xfc_read, rd_pop, ret, ret_counted, ret_ok;

    // Credits cover every read from acceptance until the engine consumes its data,
    // so the return FIFO can never overflow in legal operation.
    assign req_ready   = ~req_full & (~is_read(req_op) | (credits_reg < CRED_MAX));
    assign accept      = req_valid & req_ready;
    assign rd_accept   = accept & is_read(req_op);
    assign xfc         = arb_rts & arb_rtr;
    assign xfc_read    = xfc & is_read(req_head.op);
    assign rd_pop      = rd_valid & rd_ready;
    assign ret         = bcast_xfc[CLIENT_IDX];
    assign ret_counted = ret & (rd_outstanding_reg != 3'd0);
    assign ret_ok      = ret_counted & (~rd_full | rd_pop);

    assign req_in = '{addr: req_addr, wrdata: req_wrdata, op: req_op};

    sync_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk   (clk),
        .rst_  (rst_),
        .push  (accept),
        .din   (req_in),
        .pop   (xfc),
        .dout  (req_head),
        .full  (req_full),
        .empty (req_empty)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RD_DEPTH)) u_rd_fifo (
        .clk   (clk),
        .rst_  (rst_),
        .push  (ret_ok),
        .din   (bcast_data),
        .pop   (rd_pop),
        .dout  (rd_data),
        .full  (rd_full),
        .empty (rd_empty)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            credits_reg        <= '0;
            rd_outstanding_reg <= '0;
            err_reg            <= 1'b0;
        end else begin
            case ({rd_accept, rd_pop})
                2'b10:   credits_reg <= credits_reg + 1'b1;
                2'b01:   credits_reg <= credits_reg - 1'b1;
                default: credits_reg <= credits_reg;
            endcase
            case ({xfc_read, ret_counted})
                2'b10:   rd_outstanding_reg <= rd_outstanding_reg + 3'd1;
                2'b01:   rd_outstanding_reg <= rd_outstanding_reg - 3'd1;
                default: rd_outstanding_reg <= rd_outstanding_reg;
            endcase
            if (ret & ~ret_ok) err_reg <= 1'b1;
        end
    end

    assign arb_rts        = ~req_empty;
    assign arb_addr       = req_head.addr;
    assign arb_wrdata     = req_head.wrdata;
    assign arb_op         = req_head.op;
    assign rd_valid       = ~rd_empty;
    assign rd_outstanding = rd_outstanding_reg;
    assign err            = err_reg;
    assign busy           = ~req_empty | (rd_outstanding_reg != 3'd0) | ~rd_empty;

endmodule

// File: tb/tb_mem_client_port.sv
// Bench for mem_client_port: directed vector table, hand-written corner sequences
// and a randomized run against a queue-based reference model.
module tb_mem_client_port;

    localparam int IDX = 1;
    localparam logic [2:0] OWN = 3'b010;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [16:0] req_addr = '0;
    logic [31:0] req_wrdata = '0;
    logic [3:0]  req_op = '0;
    logic        arb_rts;
    logic        arb_rtr = 1'b0;
    logic [16:0] arb_addr;
    logic [31:0] arb_wrdata;
    logic [3:0]  arb_op;
    logic [31:0] bcast_data = '0;
    logic [2:0]  bcast_xfc = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic [2:0]  rd_outstanding;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_client_port #(.REQ_DEPTH(4), .RD_DEPTH(4), .CLIENT_IDX(IDX)) dut (
        .clk            (clk),
        .rst_           (rst_),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_wrdata     (req_wrdata),
        .req_op         (req_op),
        .arb_rts        (arb_rts),
        .arb_rtr        (arb_rtr),
        .arb_addr       (arb_addr),
        .arb_wrdata     (arb_wrdata),
        .arb_op         (arb_op),
        .bcast_data     (bcast_data),
        .bcast_xfc      (bcast_xfc),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_data        (rd_data),
        .rd_outstanding (rd_outstanding),
        .busy           (busy),
        .err            (err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [3:0] op, input logic [16:0] a,
                         input logic [31:0] wd, input logic rtr, input logic [2:0] bx,
                         input logic [31:0] bd, input logic rdr);
        req_valid = rv; req_op = op; req_addr = a; req_wrdata = wd;
        arb_rtr = rtr; bcast_xfc = bx; bcast_data = bd; rd_ready = rdr;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".req_ready"}, req_ready, 1);
        chk({tag, ".arb_rts"}, arb_rts, 0);
        chk({tag, ".arb_addr"}, arb_addr, 0);
        chk({tag, ".arb_wrdata"}, arb_wrdata, 0);
        chk({tag, ".arb_op"}, arb_op, 0);
        chk({tag, ".rd_valid"}, rd_valid, 0);
        chk({tag, ".rd_data"}, rd_data, 0);
        chk({tag, ".rd_outstanding"}, rd_outstanding, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".err"}, err, 0);
    endtask

    typedef struct {
        logic rv; logic [3:0] op; logic [16:0] addr; logic [31:0] wd;
        logic rtr; logic [2:0] bx; logic [31:0] bd; logic rdr;
        logic e_ready; logic e_rts; logic [16:0] e_addr; logic [3:0] e_op; logic [31:0] e_wd;
        logic [2:0] e_outs; logic e_rvld; logic [31:0] e_rdata; logic e_busy;
    } vec_t;

    vec_t tbl[20];

    typedef struct {logic [16:0] a; logic [31:0] d; logic [3:0] op;} mreq_t;
    mreq_t       mq[$];
    logic [31:0] mrd[$];
    int          m_cred, m_outs;
    logic        m_err;

    initial begin
        // single write, read round trip, backpressure with in-order drain
        tbl[0]  = '{1, 4'hF, 17'h10,    32'hDEADBEEF, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 1, 0, 0, 0,  1, 1, 17'h10, 4'hF, 32'hDEADBEEF, 0, 0, 0, 1};
        tbl[2]  = '{0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 4'h0, 17'h1FFFF, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 1, 0, 0, 0,  1, 1, 17'h1FFFF, 0, 0, 0, 0, 0, 1};
        tbl[5]  = '{0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 1, 0, 0, 1};
        tbl[6]  = '{0, 0, 0, 0, 1, OWN, 32'h12345678, 0,  1, 0, 0, 0, 0, 1, 0, 0, 1};
        tbl[7]  = '{0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 32'h12345678, 1};
        tbl[8]  = '{0, 0, 0, 0, 1, 0, 0, 1,  1, 0, 0, 0, 0, 0, 1, 32'h12345678, 1};
        tbl[9]  = '{0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{1, 4'hF, 17'h100, 32'hB0000100, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[11] = '{1, 4'hF, 17'h101, 32'hB0000101, 0, 0, 0, 0,  1, 1, 17'h100, 4'hF, 32'hB0000100, 0, 0, 0, 1};
        tbl[12] = '{1, 4'hF, 17'h102, 32'hB0000102, 0, 0, 0, 0,  1, 1, 17'h100, 4'hF, 32'hB0000100, 0, 0, 0, 1};
        tbl[13] = '{1, 4'hF, 17'h103, 32'hB0000103, 0, 0, 0, 0,  1, 1, 17'h100, 4'hF, 32'hB0000100, 0, 0, 0, 1};
        tbl[14] = '{1, 4'hF, 17'h104, 32'hB0000104, 0, 0, 0, 0,  0, 1, 17'h100, 4'hF, 32'hB0000100, 0, 0, 0, 1};
        tbl[15] = '{0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 17'h100, 4'hF, 32'hB0000100, 0, 0, 0, 1};
        tbl[16] = '{0, 0, 0, 0, 1, 0, 0, 0,  1, 1, 17'h101, 4'hF, 32'hB0000101, 0, 0, 0, 1};
        tbl[17] = '{0, 0, 0, 0, 1, 0, 0, 0,  1, 1, 17'h102, 4'hF, 32'hB0000102, 0, 0, 0, 1};
        tbl[18] = '{0, 0, 0, 0, 1, 0, 0, 0,  1, 1, 17'h103, 4'hF, 32'hB0000103, 0, 0, 0, 1};
        tbl[19] = '{0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0};

        #12;
        chk_reset_vals("reset");
        rst_ = 1'b1;
        cyc();

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rv, tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].rtr, tbl[i].bx, tbl[i].bd, tbl[i].rdr);
            #1;
            $display("vec %0d: rv=%0b op=%h addr=%h rtr=%0b bx=%b rdr=%0b -> ready=%0b rts=%0b arb_addr=%h rd_valid=%0b rd_data=%h",
                     i, tbl[i].rv, tbl[i].op, tbl[i].addr, tbl[i].rtr, tbl[i].bx, tbl[i].rdr,
                     req_ready, arb_rts, arb_addr, rd_valid, rd_data);
            chk($sformatf("vec%0d.req_ready", i), req_ready, tbl[i].e_ready);
            chk($sformatf("vec%0d.arb_rts", i), arb_rts, tbl[i].e_rts);
            chk($sformatf("vec%0d.arb_addr", i), arb_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d.arb_op", i), arb_op, tbl[i].e_op);
            chk($sformatf("vec%0d.arb_wrdata", i), arb_wrdata, tbl[i].e_wd);
            chk($sformatf("vec%0d.rd_outstanding", i), rd_outstanding, tbl[i].e_outs);
            chk($sformatf("vec%0d.rd_valid", i), rd_valid, tbl[i].e_rvld);
            chk($sformatf("vec%0d.rd_data", i), rd_data, tbl[i].e_rdata);
            chk($sformatf("vec%0d.busy", i), busy, tbl[i].e_busy);
            chk($sformatf("vec%0d.err", i), err, 0);
            cyc();
        end

        // Credit limit: four reads fill the credits, a fifth stalls while a write passes.
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'h0, 17'(i), 0, 1, 0, 0, 0);
            #1;
            chk($sformatf("credit.read%0d.ready", i), req_ready, 1);
            $display("credit: read %0d offered, ready=%0b", i, req_ready);
            cyc();
        end
        #1;
        chk("credit.read5.ready", req_ready, 0);
        req_op = 4'hF; req_addr = 17'h55;
        #1;
        chk("credit.write.ready", req_ready, 1);
        $display("credit: 5th read stalled, write accepted instead");
        cyc();
        req_valid = 1'b0;
        repeat (3) cyc();
        chk("credit.outstanding4", rd_outstanding, 4);
        for (int i = 0; i < 4; i++) begin
            bcast_xfc = OWN; bcast_data = 32'hA0 + 32'(i);
            cyc();
        end
        bcast_xfc = '0;
        #1;
        chk("credit.outstanding0", rd_outstanding, 0);
        chk("credit.rd_valid", rd_valid, 1);
        chk("credit.rd_data0", rd_data, 32'hA0);
        req_valid = 1'b1; req_op = 4'h0;
        #1;
        chk("credit.still_stalled", req_ready, 0);
        rd_ready = 1'b1;
        #1;
        chk("credit.pop_same_cycle", req_ready, 0);
        cyc();
        rd_ready = 1'b0;
        #1;
        chk("credit.readmitted", req_ready, 1);
        req_valid = 1'b0;
        rd_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            #1;
            chk($sformatf("credit.rd_data%0d", i), rd_data, 32'hA0 + 32'(i));
            $display("credit: rd pop data=%h", rd_data);
            cyc();
        end
        rd_ready = 1'b0;
        #1;
        chk("credit.drained_busy", busy, 0);

        // Reset mid-flight with two reads outstanding and a queued write.
        drive(1, 4'h0, 17'h7, 0, 1, 0, 0, 0);
        cyc();
        req_addr = 17'h8;
        cyc();
        req_valid = 1'b0;
        cyc();
        chk("midrst.outstanding2", rd_outstanding, 2);
        drive(1, 4'hF, 17'h9, 32'h99, 0, 0, 0, 0);
        cyc();
        req_valid = 1'b0; req_op = 4'h0;
        #1;
        chk("midrst.rts_before", arb_rts, 1);
        rst_ = 1'b0;
        #1;
        chk_reset_vals("midrst");
        $display("midrst: reset applied, outstanding=%0d busy=%0b", rd_outstanding, busy);
        cyc();
        rst_ = 1'b1;
        cyc();
        chk("midrst.busy_after", busy, 0);

        // Stray returns: another client's bit is ignored, our own sets err for good.
        drive(0, 0, 0, 0, 0, 3'b001, 32'hCAFE0001, 0);
        cyc();
        bcast_xfc = 3'b100;
        cyc();
        bcast_xfc = '0;
        #1;
        chk("err.other_client", err, 0);
        chk("err.other_no_data", rd_valid, 0);
        bcast_xfc = OWN; bcast_data = 32'hCAFE0002;
        cyc();
        bcast_xfc = '0;
        #1;
        chk("err.set", err, 1);
        chk("err.dropped", rd_valid, 0);
        chk("err.outstanding", rd_outstanding, 0);
        repeat (3) cyc();
        chk("err.sticky", err, 1);
        $display("err: stray return flagged, err=%0b", err);

        rst_ = 1'b0;
        #3;
        rst_ = 1'b1;
        cyc();

        // Randomized run against the queue model.
        m_cred = 0; m_outs = 0; m_err = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            logic        rv, rtr, rdr, own, e_ready, e_rts, e_rvld, acc, xfc, pop, xfc_read, fifo_full;
            logic [3:0]  op;
            logic [2:0]  bx;
            logic [31:0] bd;
            rv  = 1'($urandom_range(0, 1));
            op  = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            rtr = ($urandom_range(0, 9) < 6);
            rdr = 1'($urandom_range(0, 1));
            own = (m_outs > 0) && ($urandom_range(0, 9) < 4);
            bx  = (3'($urandom_range(0, 7)) & ~OWN) | (own ? OWN : 3'b000);
            bd  = $urandom;
            drive(rv, op, 17'($urandom), $urandom, rtr, bx, bd, rdr);
            #1;
            e_ready = (mq.size() < 4) && (op != 4'h0 || m_cred < 4);
            e_rts   = (mq.size() != 0);
            e_rvld  = (mrd.size() != 0);
            chk("rand.req_ready", req_ready, e_ready);
            chk("rand.arb_rts", arb_rts, e_rts);
            chk("rand.arb_addr", arb_addr, e_rts ? mq[0].a : 0);
            chk("rand.arb_wrdata", arb_wrdata, e_rts ? mq[0].d : 0);
            chk("rand.arb_op", arb_op, e_rts ? mq[0].op : 0);
            chk("rand.rd_valid", rd_valid, e_rvld);
            chk("rand.rd_data", rd_data, e_rvld ? mrd[0] : 0);
            chk("rand.rd_outstanding", rd_outstanding, 32'(m_outs));
            chk("rand.busy", busy, e_rts || m_outs != 0 || e_rvld);
            chk("rand.err", err, m_err);

            acc       = rv && e_ready;
            xfc       = e_rts && rtr;
            xfc_read  = xfc && mq[0].op == 4'h0;
            pop       = e_rvld && rdr;
            fifo_full = (mrd.size() >= 4);
            if (acc) $display("rand %0d: accept %s addr=%h", c, (op == 0) ? "read" : "write", req_addr);
            if (pop) $display("rand %0d: return data=%h", c, mrd[0]);
            if (acc && op == 4'h0) m_cred++;
            if (pop) m_cred--;
            if (xfc) void'(mq.pop_front());
            if (acc) mq.push_back('{req_addr, req_wrdata, op});
            if (pop) void'(mrd.pop_front());
            if (own) begin
                if (m_outs == 0 || (fifo_full && !pop)) m_err = 1'b1;
                else mrd.push_back(bd);
            end
            m_outs = m_outs + (xfc_read ? 1 : 0) - ((own && m_outs > 0) ? 1 : 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
